// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver and the byte/status coming back.
interface uart_rx_if;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       rx_active;

  modport master (output rx_serial, input rx_dv, rx_byte, rx_error, rx_active);
  modport slave  (input rx_serial, output rx_dv, rx_byte, rx_error, rx_active);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, framing-error
// detection with a wait-for-idle state so a held-low line reports once.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Error,
  output logic       o_Rx_Active
);

  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        err_q, err_d;
  logic        active_q, active_d;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit; a short low pulse is dropped silently.
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d  = DATA;
            active_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      CLEANUP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break produces a single error.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Error  = err_q;
  assign o_Rx_Active = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;
  localparam int CPB     = 8;
  localparam int MAX_LAT = 9 * CPB + (CPB - 1) / 2 + 5;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   act_cnt = 0;
  logic [7:0] last_good = 8'h00;
  exp_t q[$];

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_Serial (bus.rx_serial),
    .o_Rx_DV     (bus.rx_dv),
    .o_Rx_Byte   (bus.rx_byte),
    .o_Rx_Error  (bus.rx_error),
    .o_Rx_Active (bus.rx_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
  endtask

  // Monitor: pops the expected outcome on every DV/error pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) act_cnt = 0;
    else if (bus.rx_active) act_cnt++;
    if (bus.rx_dv && bus.rx_error) chk("dv_err_overlap", 1, 0);
    if (!rst && (bus.rx_dv || bus.rx_error)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", int'(bus.rx_dv) * 2 + int'(bus.rx_error), 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_err", int'(bus.rx_error), int'(e.is_err));
        chk("rx_byte", int'(bus.rx_byte), int'(e.data));
        chk_range("active_cycles", act_cnt, 9 * CPB - CPB / 2, 9 * CPB + CPB / 2 + 2);
        if (!e.is_err) chk_range("dv_latency", cyc - e.t0, 1, MAX_LAT);
      end
      act_cnt = 0;
    end
  end

  task automatic idle_bits(input int n);
    bus.rx_serial = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx_serial = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Reference model: frame outcome decided only by the stop bit value.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    e.t0 = cyc;
    e.is_err = !stop_bit;
    e.data = stop_bit ? d : last_good;
    if (stop_bit) last_good = d;
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_dv"}, int'(bus.rx_dv), 0);
    chk({nm, "_err"}, int'(bus.rx_error), 0);
    chk({nm, "_active"}, int'(bus.rx_active), 0);
    chk({nm, "_byte"}, int'(bus.rx_byte), 0);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (q.size() != 0 && t < 4 * 10 * CPB) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk({nm, "_drained"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       sb;
    bus.rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    idle_bits(2);

    // Good byte
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    drain("good");

    // Glitch on idle line
    act_cnt = 0;
    bus.rx_serial = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_bits(3);
    chk("glitch_active_cycles", act_cnt, 0);
    chk("glitch_q", q.size(), 0);

    // Framing error keeps the previous byte
    send_frame(8'h11, 1'b1);
    send_frame(8'h3C, 1'b0);
    idle_bits(2);
    drain("framing");

    // Break: 30 bit times low gives exactly one error, then a good byte
    begin
      exp_t e;
      e.t0 = cyc; e.is_err = 1'b1; e.data = last_good;
      q.push_back(e);
    end
    bus.rx_serial = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    idle_bits(2);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);
    drain("break");

    // Reset during data bit 4 aborts the frame silently
    d = 8'h6B;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    bus.rx_serial = d[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rx_serial = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("midreset");
    rst = 1'b0;
    last_good = 8'h00;
    idle_bits(3);
    chk("midreset_no_pulse_q", q.size(), 0);
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    drain("after_reset");

    // Back-to-back, no gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(2);
    drain("b2b");

    // Random frames with occasional bad stop bits and variable gaps
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, sb);
      idle_bits(sb ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3)));
    end
    idle_bits(2);
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $finish;
  end
endmodule
